// File: rtl/riscv_rtype_exec_stage_pkg.sv
// Shared constants and ALU op encoding for the
// RV32I R-type execute stage.
package riscv_rtype_exec_stage_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_NOP
  } alu_op_e;

endpackage

// File: rtl/riscv_rtype_exec_stage_alu.sv
// Combinational RV32I integer ALU.
// Shift amount is always taken from B[4:0].
module riscv_alu
  import riscv_rtype_exec_stage_pkg::*;
#(
  parameter int n = 32
) (
  input  alu_op_e        op_i,
  input  logic [n-1:0]   a_i,
  input  logic [n-1:0]   b_i,
  output logic [n-1:0]   res_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Select the operation; NOP yields zero
  always_comb begin
    res_o = '0;
    unique case (op_i)
      ALU_ADD:  res_o = a_i + b_i;
      ALU_SUB:  res_o = a_i - b_i;
      ALU_SLL:  res_o = a_i << shamt;
      ALU_SLT:  res_o = {{(n-1){1'b0}},
                         $signed(a_i) < $signed(b_i)};
      ALU_SLTU: res_o = {{(n-1){1'b0}}, a_i < b_i};
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_SRL:  res_o = a_i >> shamt;
      ALU_SRA:  res_o = $signed(a_i) >>> shamt;
      ALU_OR:   res_o = a_i | b_i;
      ALU_AND:  res_o = a_i & b_i;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_rtype_exec_stage.sv
// Registered R-type execute stage: decode funct3/funct7,
// run the ALU, capture the result on the next edge.
module riscv_rtype_exec_stage
  import riscv_rtype_exec_stage_pkg::*;
#(
  parameter int n = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   instruction_R,
  input  logic [n-1:0]  Read_data1_R,
  input  logic [n-1:0]  Read_data2_R,
  output logic [n-1:0]  ALUResult_R
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         f7b5;
  alu_op_e      op_d;
  logic [n-1:0] res_d;
  logic [n-1:0] res_q;

  assign opcode = instruction_R[6:0];
  assign funct3 = instruction_R[14:12];
  assign f7b5   = instruction_R[30];

  // Register indices and the rest of funct7
  // play no part in this stage.
  logic unused_fields;
  assign unused_fields = ^{instruction_R[31],
                           instruction_R[29:15],
                           instruction_R[11:7]};

  // Decode; non-OP opcodes map to NOP (result 0)
  always_comb begin
    op_d = ALU_NOP;
    if (opcode == OP_R) begin
      unique case (funct3)
        F3_ADD:  op_d = f7b5 ? ALU_SUB : ALU_ADD;
        F3_SLL:  op_d = ALU_SLL;
        F3_SLT:  op_d = ALU_SLT;
        F3_SLTU: op_d = ALU_SLTU;
        F3_XOR:  op_d = ALU_XOR;
        F3_SR:   op_d = f7b5 ? ALU_SRA : ALU_SRL;
        F3_OR:   op_d = ALU_OR;
        F3_AND:  op_d = ALU_AND;
        default: op_d = ALU_NOP;
      endcase
    end
  end

  riscv_alu #(.n(n)) u_alu (
    .op_i  (op_d),
    .a_i   (Read_data1_R),
    .b_i   (Read_data2_R),
    .res_o (res_d)
  );

  // Result register; reset is active-high
  // despite the historical port name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) res_q <= '0;
    else       res_q <= res_d;
  end

  assign ALUResult_R = res_q;

endmodule

// File: tb/tb_riscv_rtype_exec_stage.sv
// Scoreboard bench for the R-type execute stage:
// directed spec cases plus random ops vs a reference.
module tb_riscv_rtype_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] res;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  riscv_rtype_exec_stage #(.n(32)) dut (
    .clk           (clk),
    .rst_n         (rst),
    .instruction_R (instr),
    .Read_data1_R  (a),
    .Read_data2_R  (b),
    .ALUResult_R   (res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h",
               nm, act, exp);
    end
  endtask

  // Reference: RV32I OP semantics in plain arithmetic
  function automatic logic [31:0] ref_model(
      input logic [31:0] ins,
      input logic [31:0] x,
      input logic [31:0] y);
    int unsigned ux = x;
    int unsigned uy = y;
    int          sx = x;
    int          sy = y;
    int unsigned sh = uy % 32;
    logic [2:0]  f3 = ins[14:12];
    logic        alt = ins[30];
    if (ins[6:0] != 7'h33) return 32'h0;
    case (f3)
      3'd0: return alt ? ux - uy : ux + uy;
      3'd1: return ux << sh;
      3'd2: return (sx < sy) ? 32'd1 : 32'd0;
      3'd3: return (ux < uy) ? 32'd1 : 32'd0;
      3'd4: return ux ^ uy;
      3'd5: return alt ? 32'(sx >>> sh) : ux >> sh;
      3'd6: return ux | uy;
      default: return ux & uy;
    endcase
  endfunction

  function automatic logic [31:0] mk(
      input logic [6:0] f7,
      input logic [2:0] f3);
    logic [9:0] regs = 10'($urandom);
    logic [4:0] rd = 5'($urandom);
    return {f7, regs, f3, rd, 7'h33};
  endfunction

  // Drive one op at negedge and queue its expectation
  task automatic issue(input string nm,
                       input logic [31:0] ins,
                       input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    instr = ins;
    a = x;
    b = y;
    exp_q.push_back(rst ? 32'h0 : ref_model(ins, x, y));
    name_q.push_back(nm);
  endtask

  // Monitor: compare each captured result
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        chk(name_q.pop_front(), res, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins;
    logic [31:0] x;
    logic [31:0] y;
    int          wait_cyc;

    // Reset held: arbitrary ops still give 0
    for (int i = 0; i < 4; i++)
      issue("reset_hold", mk(7'h00, 3'd0),
            32'h1234 + i, 32'h77);
    @(negedge clk);
    rst = 1'b0;

    issue("add", mk(7'h00, 3'd0), 32'd5, 32'd8);
    issue("sub", mk(7'h20, 3'd0), 32'd1, 32'd2);
    issue("and", mk(7'h20, 3'd7), 32'h10, 32'h5);
    issue("or",  mk(7'h20, 3'd6), 32'h8, 32'h15);
    issue("sll", mk(7'h00, 3'd1), 32'd1, 32'd2);
    issue("srl", mk(7'h00, 3'd5), 32'h80000000, 32'd31);
    issue("sra", mk(7'h20, 3'd5), 32'h80000000, 32'd31);
    issue("slt_pos", mk(7'h00, 3'd2), 32'h23, 32'd1);
    issue("slt_neg", mk(7'h00, 3'd2), 32'hFFFFFFFF, 32'd1);
    issue("sltu", mk(7'h00, 3'd3), 32'hFFFFFFFF, 32'd1);
    issue("xor", mk(7'h20, 3'd4), 32'hF0F0, 32'hFF00);
    issue("non_r", 32'h00000013, 32'd5, 32'd8);
    issue("zero_word", 32'h0, 32'd5, 32'd8);
    issue("sll_shamt", mk(7'h00, 3'd1), 32'd1, 32'hFFFFFFE4);

    // Mid-cycle input change must not move the output
    issue("stable_pre", mk(7'h00, 3'd0), 32'd100, 32'd23);
    @(posedge clk);
    #2;
    instr = mk(7'h00, 3'd6);
    a = 32'hDEAD0000;
    b = 32'h0000BEEF;
    #1;
    chk("stable_mid", res, 32'd123);

    // Async reset mid-run clears immediately
    issue("pre_reset", mk(7'h00, 3'd6), 32'hA5, 32'h5A00);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", res, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset coincident with an edge: reset wins
    issue("pre_edge", mk(7'h00, 3'd4), 32'h3, 32'hC);
    @(negedge clk);
    instr = mk(7'h00, 3'd0);
    a = 32'd40;
    b = 32'd2;
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("reset_at_edge", res, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Random back-to-back ops
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8)
        ins = mk(7'($urandom), 3'($urandom));
      else
        ins = $urandom;
      case ($urandom_range(0, 3))
        0: x = 32'h80000000;
        1: x = 32'hFFFFFFFF;
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      issue("random", ins, x, y);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
